// File: rtl/histeq_master_fsm.sv
// -----------------------------------------------------------------------------
// histeq_master_fsm
//
// Top-level sequencer for histogram_equalizer_core. It steps the core through
// its three phases (histogram, CDF, divider/output write), separated by
// one-cycle gaps so each sub-block sees its start level drop cleanly. It also
// flags the end of input data by watching the histogram read address, and it
// reports completion, a run cycle count and an optional watchdog error.
//
// Optional feature macro: HISTEQ_PHASE_TIMEOUT_EN
//   defined   : per-phase watchdog; a phase that runs TIMEOUT_CYCLES cycles
//               without its done flag sends the FSM to ERROR (reset-only exit)
//   undefined : no watchdog, error tied low, ERROR unreachable
//
// Ports:
//   clock                       system clock
//   reset                       synchronous, active-high reset
//   start                       run request, sampled only in IDLE
//   histogram_input_mem_raddr0  histogram read address 0 (monitored)
//   histogram_computation_done  histogram phase done (level)
//   cdf_done                    CDF phase done (level)
//   divider_done                divider/output phase done (level)
//   start_histogram             high exactly while in HIST
//   start_cdf                   high exactly while in CDF
//   start_divider               high exactly while in DIV
//   input_mem_read_finished     last input word read seen in HIST (sticky)
//   busy                        high in HIST..DONE
//   done                        one-cycle completion pulse
//   error                       sticky watchdog error
//   fsm_state                   current state encoding
//   total_cycles                cycles spent in HIST..DIV of the last/current run
//
// All outputs are registered: they are decoded from the next state so they
// line up with the state register.
// -----------------------------------------------------------------------------
module histeq_master_fsm #(
  parameter logic [15:0] LAST_INPUT_ADDR = 16'd4095,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd1000000,
  parameter int unsigned CYCLE_CNT_W     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            histogram_input_mem_raddr0,
  input  logic                   histogram_computation_done,
  input  logic                   cdf_done,
  input  logic                   divider_done,
  output logic                   start_histogram,
  output logic                   start_cdf,
  output logic                   start_divider,
  output logic                   input_mem_read_finished,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             fsm_state,
  output logic [CYCLE_CNT_W-1:0] total_cycles
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHist  = 3'd1,
    StGap1  = 3'd2,
    StCdf   = 3'd3,
    StGap2  = 3'd4,
    StDiv   = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } state_e;

  localparam logic [CYCLE_CNT_W-1:0] CycOne = {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_CNT_W-1:0] CycMax = {CYCLE_CNT_W{1'b1}};

  state_e state_q, state_d;
  logic   timeout;
  logic   counting;

`ifdef HISTEQ_PHASE_TIMEOUT_EN
  logic [23:0] phase_cnt;
  logic        in_phase;
  logic        phase_flag;

  always_comb begin
    in_phase   = 1'b0;
    phase_flag = 1'b0;
    case (state_q)
      StHist: begin in_phase = 1'b1; phase_flag = histogram_computation_done; end
      StCdf:  begin in_phase = 1'b1; phase_flag = cdf_done;                   end
      StDiv:  begin in_phase = 1'b1; phase_flag = divider_done;               end
      default: ;
    endcase
    // A done flag in the limit cycle wins over the timeout.
    timeout = in_phase && !phase_flag && (phase_cnt == (TIMEOUT_CYCLES - 24'd1));
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state. Done flags are only looked at in their own phase, so a stale
  // level from a previous run cannot skip a phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start)                      state_d = StHist;
      StHist:  if (histogram_computation_done) state_d = StGap1;
      StGap1:                                  state_d = StCdf;
      StCdf:   if (cdf_done)                   state_d = StGap2;
      StGap2:                                  state_d = StDiv;
      StDiv:   if (divider_done)               state_d = StDone;
      StDone:                                  state_d = StIdle;
      StError:                                 state_d = StError;
      default:                                 state_d = StIdle;
    endcase
    if (timeout) begin
      state_d = StError;
    end
  end

  // Cycle counter runs through both gaps as well as the three phases.
  assign counting = (state_q == StHist) || (state_q == StGap1) || (state_q == StCdf) ||
                    (state_q == StGap2) || (state_q == StDiv);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= StIdle;
      fsm_state               <= 3'd0;
      start_histogram         <= 1'b0;
      start_cdf               <= 1'b0;
      start_divider           <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      error                   <= 1'b0;
      input_mem_read_finished <= 1'b0;
      total_cycles            <= '0;
`ifdef HISTEQ_PHASE_TIMEOUT_EN
      phase_cnt               <= 24'd0;
`endif
    end else begin
      state_q         <= state_d;
      fsm_state       <= state_d;
      start_histogram <= (state_d == StHist);
      start_cdf       <= (state_d == StCdf);
      start_divider   <= (state_d == StDiv);
      busy            <= (state_d != StIdle) && (state_d != StError);
      done            <= (state_d == StDone);
`ifdef HISTEQ_PHASE_TIMEOUT_EN
      error           <= (state_d == StError);
      // Counter value equals the number of cycles already spent in the phase.
      if ((state_d == state_q) &&
          ((state_q == StHist) || (state_q == StCdf) || (state_q == StDiv))) begin
        phase_cnt <= phase_cnt + 24'd1;
      end else begin
        phase_cnt <= 24'd0;
      end
`else
      error           <= 1'b0;
`endif

      if ((state_q == StIdle) && start) begin
        total_cycles <= '0;
      end else if (counting && (total_cycles != CycMax)) begin
        total_cycles <= total_cycles + CycOne;
      end

      if (state_d == StIdle) begin
        input_mem_read_finished <= 1'b0;
      end else if ((state_q == StHist) &&
                   (histogram_input_mem_raddr0 == LAST_INPUT_ADDR)) begin
        input_mem_read_finished <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_histeq_master_fsm.sv
module tb_histeq_master_fsm;

  logic        clock = 1'b0;
  logic        reset, start, hd, cd, dd;
  logic [15:0] raddr;
  logic        sh, sc, sd, rf, bz, dn, er;
  logic [2:0]  st;
  logic [31:0] tot;

  always #5 clock = ~clock;

  histeq_master_fsm dut (
    .clock                      (clock),
    .reset                      (reset),
    .start                      (start),
    .histogram_input_mem_raddr0 (raddr),
    .histogram_computation_done (hd),
    .cdf_done                   (cd),
    .divider_done               (dd),
    .start_histogram            (sh),
    .start_cdf                  (sc),
    .start_divider              (sd),
    .input_mem_read_finished    (rf),
    .busy                       (bz),
    .done                       (dn),
    .error                      (er),
    .fsm_state                  (st),
    .total_cycles               (tot)
  );

`ifdef HISTEQ_PHASE_TIMEOUT_EN
  logic        reset2, start2, hd2, cd2, dd2;
  logic        sh2, sc2, sd2, rf2, bz2, dn2, er2;
  logic [2:0]  st2;
  logic [31:0] tot2;

  histeq_master_fsm #(.TIMEOUT_CYCLES(24'd16)) dut_to (
    .clock                      (clock),
    .reset                      (reset2),
    .start                      (start2),
    .histogram_input_mem_raddr0 (16'd0),
    .histogram_computation_done (hd2),
    .cdf_done                   (cd2),
    .divider_done               (dd2),
    .start_histogram            (sh2),
    .start_cdf                  (sc2),
    .start_divider              (sd2),
    .input_mem_read_finished    (rf2),
    .busy                       (bz2),
    .done                       (dn2),
    .error                      (er2),
    .fsm_state                  (st2),
    .total_cycles               (tot2)
  );

  task automatic tick2(input logic r, s, h, c, d);
    reset2 = r; start2 = s; hd2 = h; cd2 = c; dd2 = d;
    @(negedge clock);
  endtask
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  st;
    logic        sh, sc, sd, rf, bz, dn, er;
    logic [31:0] tot;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: phase numbers follow the state encoding.
  int          m_st  = 0;
  logic        m_rf  = 1'b0;
  logic [31:0] m_tot = '0;

  // Drive one cycle of inputs, predict the post-edge outputs, queue them.
  task automatic tick(input logic r, s, input logic [15:0] a, input logic h, c, d);
    int   nst;
    exp_t e;
    reset = r; start = s; raddr = a; hd = h; cd = c; dd = d;
    if (r) begin
      m_st = 0; m_rf = 1'b0; m_tot = '0;
    end else begin
      nst = m_st;
      if (m_st == 0 && s) nst = 1;
      else if (m_st == 1 && h) nst = 2;
      else if (m_st == 2) nst = 3;
      else if (m_st == 3 && c) nst = 4;
      else if (m_st == 4) nst = 5;
      else if (m_st == 5 && d) nst = 6;
      else if (m_st == 6) nst = 0;
      if (m_st == 0 && s) m_tot = '0;
      else if (m_st >= 1 && m_st <= 5 && m_tot != 32'hffff_ffff) m_tot = m_tot + 1;
      if (nst == 0) m_rf = 1'b0;
      else if (m_st == 1 && a == 16'd4095) m_rf = 1'b1;
      m_st = nst;
    end
    e.st  = 3'(m_st);
    e.sh  = (m_st == 1);
    e.sc  = (m_st == 3);
    e.sd  = (m_st == 5);
    e.rf  = m_rf;
    e.bz  = (m_st >= 1 && m_st <= 6);
    e.dn  = (m_st == 6);
    e.er  = 1'b0;
    e.tot = m_tot;
    sb.push_back(e);
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("state", 32'(st), 32'(mon_e.st));
      check("start_hist", 32'(sh), 32'(mon_e.sh));
      check("start_cdf", 32'(sc), 32'(mon_e.sc));
      check("start_div", 32'(sd), 32'(mon_e.sd));
      check("read_fin", 32'(rf), 32'(mon_e.rf));
      check("busy", 32'(bz), 32'(mon_e.bz));
      check("done", 32'(dn), 32'(mon_e.dn));
      check("error", 32'(er), 32'(mon_e.er));
      check("total", tot, mon_e.tot);
    end
  end

  int npulse;

  initial begin
`ifdef HISTEQ_PHASE_TIMEOUT_EN
    reset2 = 1'b1; start2 = 1'b0; hd2 = 1'b0; cd2 = 1'b0; dd2 = 1'b0;
`endif
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check("reset_state", {29'd0, st}, 32'd0);
    check("reset_outs", {sh, sc, sd, rf, bz, dn, er}, 32'd0);
    check("reset_total", tot, 32'd0);
    tick(0, 0, 0, 0, 0, 0);

    // 1. nominal run: HIST 1..50, GAP1 51, CDF 52..80, GAP2 81, DIV 82..120
    npulse = 0;
    for (int c = 0; c <= 124; c++) begin
      tick(0, c == 0, 0, c == 50, c == 80, c == 120);
      if (dn === 1'b1) npulse++;
      if (c == 120) begin
        check("s1_done_state", {29'd0, st}, 32'd6);
        check("s1_total", tot, 32'd120);
      end
    end
    check("s1_pulses", npulse, 32'd1);
    check("s1_idle", {29'd0, st}, 32'd0);

    // 2. address sweep during HIST
    tick(0, 1, 0, 0, 0, 0);
    for (int a = 0; a < 4096; a++) begin
      if (a == 4095) check("s2_rf_before", {31'd0, rf}, 32'd0);
      tick(0, 0, 16'(a), 0, 0, 0);
    end
    check("s2_rf_set", {31'd0, rf}, 32'd1);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    check("s2_rf_done", {31'd0, rf}, 32'd1);
    tick(0, 0, 0, 0, 0, 0);
    check("s2_rf_idle", {31'd0, rf}, 32'd0);

    // 3. early hist done, start/stale done/last address while in CDF
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 16'd4095, 1, 0, 0);
    check("s3_in_cdf", {29'd0, st}, 32'd3);
    check("s3_rf", {31'd0, rf}, 32'd0);
    tick(0, 1, 0, 1, 1, 0);
    check("s3_gap2", {29'd0, st}, 32'd4);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);

    // 4. reset while in DIV
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 16'd4095, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("s4_in_div", {29'd0, st}, 32'd5);
    tick(1, 0, 0, 0, 0, 0);
    check("s4_rst_state", {29'd0, st}, 32'd0);
    check("s4_rst_outs", {sh, sc, sd, rf, bz, dn, er}, 32'd0);
    check("s4_rst_total", tot, 32'd0);
    tick(0, 1, 0, 0, 0, 0);
    check("s4_hist", {29'd0, st, sh}, 32'd3);
    check("s4_total0", tot, 32'd0);
    tick(0, 0, 0, 0, 0, 0);
    check("s4_total1", tot, 32'd1);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // 5 (watchdog absent or far away): CDF without cdf_done just waits
    for (int i = 0; i < 40; i++) tick(0, 0, 0, 0, 0, 0);
    check("s5_wait_cdf", {29'd0, st}, 32'd3);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    check("s5_idle", {29'd0, st}, 32'd0);

`ifdef HISTEQ_PHASE_TIMEOUT_EN
    // 5. timeout in CDF on the 16th cycle
    tick2(1, 0, 0, 0, 0);
    tick2(0, 1, 0, 0, 0);
    tick2(0, 0, 1, 0, 0);
    tick2(0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick2(0, 0, 0, 0, 0);
    check("to_cdf15", {29'd0, st2}, 32'd3);
    tick2(0, 0, 0, 0, 0);
    check("to_err_state", {29'd0, st2}, 32'd7);
    check("to_err_outs", {er2, sc2, bz2}, 32'd4);
    for (int i = 0; i < 4; i++) tick2(0, 1, 0, 0, 0);
    check("to_err_sticky", {28'd0, er2, st2}, 32'd15);
    tick2(1, 0, 0, 0, 0);
    check("to_rst", {28'd0, er2, st2}, 32'd0);
    // 6. divider_done on the limit cycle wins
    tick2(0, 1, 0, 0, 0);
    tick2(0, 0, 1, 0, 0);
    tick2(0, 0, 0, 0, 0);
    tick2(0, 0, 0, 1, 0);
    tick2(0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick2(0, 0, 0, 0, 0);
    check("to_div15", {29'd0, st2}, 32'd5);
    tick2(0, 0, 0, 0, 1);
    check("to_done", {28'd0, er2, st2}, 32'd6);
    tick2(0, 0, 0, 0, 0);
    check("to_idle", {28'd0, er2, st2}, 32'd0);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
